// File: rtl/key_event_queue.sv
// key_event_queue: turns debounced key press edges into key-code events with
// typematic auto-repeat and buffers them in a small valid/ready FIFO.
module key_event_queue #(
  parameter int NUM_KEYS      = 16,
  parameter int CODE_W        = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keys_db,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_repeat,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                overflow,
  input  logic                overflow_clr
);
  localparam int CNT_MAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam bit RPT_EN  = REPEAT_DELAY != 0;

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  logic                armed_q, armed_d;
  logic [NUM_KEYS-1:0] prev_q, prev_d, pend_q, pend_d, rise, sel_mask;
  logic [CODE_W-1:0]   sel_code;
  logic                press;
  state_t              state_q, state_d;
  logic [CODE_W-1:0]   rep_key_q, rep_key_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_top;
  logic                held, rep_fire;
  logic [CODE_W:0]     mem_q [FIFO_DEPTH];
  logic [CODE_W:0]     mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]      count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                push_req, push_ok, pop;
  logic [CODE_W:0]     push_entry;

  // The arming edge only snapshots the levels, so keys held through reset never fire.
  always_comb begin
    rise     = armed_q ? keys_db & ~prev_q : '0;
    prev_d   = keys_db;
    armed_d  = 1'b1;
    sel_mask = pend_q & (~pend_q + NUM_KEYS'(1));
    pend_d   = (pend_q & ~sel_mask) | rise;
    press    = |pend_q;
    sel_code = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (pend_q[i]) sel_code = CODE_W'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rep_key_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rep_key_q <= rep_key_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    held      = keys_db[rep_key_q];
    cnt_top   = state_q == S_DELAY ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_PERIOD - 1);
    state_d   = state_q;
    rep_key_d = rep_key_q;
    cnt_d     = cnt_q;
    if (RPT_EN && press) begin
      state_d   = S_DELAY;
      rep_key_d = sel_code;
      cnt_d     = '0;
    end else if (state_q != S_IDLE) begin
      state_d = !held ? S_IDLE : cnt_q == cnt_top ? S_REPEAT : state_q;
      cnt_d   = !held || cnt_q == cnt_top ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_comb rep_fire = state_q != S_IDLE && held && cnt_q == cnt_top;

  // A fresh press wins the single push slot; a coincident repeat is simply dropped.
  always_comb begin
    key_valid  = count_q != '0;
    pop        = key_valid & key_ready;
    push_req   = press | rep_fire;
    push_entry = press ? {1'b0, sel_code} : {1'b1, rep_key_q};
    push_ok    = push_req && (count_q < (PTR_W + 1)'(FIFO_DEPTH) || pop);
    mem_d      = mem_q;
    if (push_ok) mem_d[wr_q] = push_entry;
    wr_d       = wr_q + PTR_W'(push_ok);
    rd_d       = rd_q + PTR_W'(pop);
    count_d    = count_q + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop);
    overflow_d = (push_req & ~push_ok) | (overflow_q & ~overflow_clr);
    key_code   = mem_q[rd_q][CODE_W-1:0];
    key_repeat = mem_q[rd_q][CODE_W];
    overflow   = overflow_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q    <= 1'b0;
      prev_q     <= '0;
      pend_q     <= '0;
      mem_q      <= '{default: '0};
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      armed_q    <= armed_d;
      prev_q     <= prev_d;
      pend_q     <= pend_d;
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_key_event_queue.sv
// tb_key_event_queue: randomized and directed stimulus against a timestamp-based
// reference model; a negedge monitor compares the FIFO head against a scoreboard.
module tb_key_event_queue;
  localparam int NK = 16, CW = 4, D = 4, RD = 10, RP = 4;

  logic          clk = 1'b0, rst_n = 1'b0, key_ready = 1'b1, overflow_clr = 1'b0;
  logic [NK-1:0] keys_db = '0;
  logic [CW-1:0] key_code;
  logic          key_repeat, key_valid, overflow;
  int            n_vec = 0, n_err = 0, n_rep7 = 0;

  key_event_queue #(
    .NUM_KEYS(NK), .CODE_W(CW), .FIFO_DEPTH(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .keys_db(keys_db), .key_code(key_code),
    .key_repeat(key_repeat), .key_valid(key_valid), .key_ready(key_ready),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  logic          armed = 1'b0;
  logic [NK-1:0] prev = '0, pend = '0;
  bit            rep_on = 1'b0, m_ovf = 1'b0;
  int            rep_key = 0, m_cnt = 0;
  longint        next_fire = 0, cyc = 0;
  logic [CW:0]   sb[$];

  task automatic check(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    armed = 1'b0; prev = '0; pend = '0; rep_on = 1'b0; m_cnt = 0; m_ovf = 1'b0;
    sb.delete();
  endtask

  // Repeats are scheduled as absolute cycle stamps rather than a counter.
  task automatic mstep();
    logic [NK-1:0] rise;
    logic [CW:0]   ev;
    bit            pop, has, set;
    int            k;
    pop = m_cnt > 0 && key_ready;
    has = 1'b0; set = 1'b0; ev = '0;
    if (!armed) begin
      prev = keys_db; armed = 1'b1;
    end else begin
      rise = keys_db & ~prev; prev = keys_db;
      k = -1;
      for (int i = NK - 1; i >= 0; i--) if (pend[i]) k = i;
      if (k >= 0) begin
        pend[k] = 1'b0; has = 1'b1; ev = {1'b0, CW'(k)};
        rep_on = RD != 0; rep_key = k; next_fire = cyc + RD;
      end else if (rep_on) begin
        if (!keys_db[rep_key]) rep_on = 1'b0;
        else if (cyc == next_fire) begin
          has = 1'b1; ev = {1'b1, CW'(rep_key)}; next_fire = cyc + RP;
        end
      end
      pend = pend | rise;
    end
    if (has) begin
      if (m_cnt < D || pop) begin sb.push_back(ev); m_cnt++; end
      else set = 1'b1;
    end
    if (pop) m_cnt--;
    m_ovf = set || (m_ovf && !overflow_clr);
    cyc++;
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) mreset(); else mstep();

  always @(negedge clk) if (rst_n) begin
    check("valid", int'(key_valid), int'(m_cnt != 0));
    check("overflow", int'(overflow), int'(m_ovf));
    if (key_valid) begin
      if (sb.size() == 0) check("head_unexpected", int'({key_repeat, key_code}), -1);
      else begin
        check("head", int'({key_repeat, key_code}), int'(sb[0]));
        if (key_ready) begin
          void'(sb.pop_front());
          if (key_repeat && key_code == 4'd7) n_rep7++;
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    keys_db[3] = 1'b1;
    tick(2);
    check("rst_valid", int'(key_valid), 0);
    check("rst_code", int'(key_code), 0);
    check("rst_repeat", int'(key_repeat), 0);
    check("rst_ovf", int'(overflow), 0);
    rst_n = 1'b1;
    tick(20);
    keys_db[3] = 1'b0;
    tick(3);
    keys_db[3] = 1'b1;
    tick(1);
    check("lat_e0", int'(key_valid), 0);
    tick(1);
    check("lat_e1", int'(key_valid), 1);
    check("lat_code", int'(key_code), 3);
    tick(2);
    keys_db[3] = 1'b0;
    tick(5);
    keys_db[5] = 1'b1; keys_db[9] = 1'b1;
    tick(3);
    keys_db = '0;
    tick(6);
    n_rep7 = 0;
    keys_db[7] = 1'b1;
    tick(30);
    keys_db[7] = 1'b0;
    tick(12);
    check("rep7_count", n_rep7, 5);
    key_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin keys_db[i] = 1'b1; tick(1); end
    keys_db = '0;
    tick(2);
    check("ovf_set", int'(overflow), 1);
    key_ready = 1'b1;
    tick(6);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("ovf_clr", int'(overflow), 0);
    key_ready = 1'b0;
    for (int i = 1; i < 5; i++) begin keys_db = NK'(1) << i; tick(1); end
    keys_db = '0;
    tick(3);
    keys_db[6] = 1'b1;
    tick(1);
    key_ready = 1'b1;
    tick(1);
    keys_db[6] = 1'b0;
    tick(8);
    check("full_pushpop_ovf", int'(overflow), 0);
    keys_db[2] = 1'b1;
    tick(16);
    keys_db[11] = 1'b1;
    tick(14);
    key_ready = 1'b0;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(key_valid), 0);
    tick(2);
    keys_db = '0; key_ready = 1'b1; rst_n = 1'b1;
    tick(5);
    check("post_rst_empty", int'(key_valid), 0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) keys_db[$urandom_range(0, NK - 1)] ^= 1'b1;
      key_ready    = $urandom_range(0, 3) != 0;
      overflow_clr = $urandom_range(0, 15) == 0;
      tick(1);
    end
    keys_db = '0; key_ready = 1'b1; overflow_clr = 1'b0;
    tick(20);
    check("drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
